// File: rtl/mips_muldiv_pkg.sv
// Shared types and encodings for the HI/LO multiply/divide unit.
// Optional feature macro: MULDIV_MADD_EN (multiply-accumulate ops).
package mips_muldiv_pkg;

    // Operation encodings as seen on the op port
    localparam logic [3:0] OpEncMult  = 4'h0;
    localparam logic [3:0] OpEncMultu = 4'h1;
    localparam logic [3:0] OpEncDiv   = 4'h2;
    localparam logic [3:0] OpEncDivu  = 4'h3;
    localparam logic [3:0] OpEncMthi  = 4'h4;
    localparam logic [3:0] OpEncMtlo  = 4'h5;
    localparam logic [3:0] OpEncMadd  = 4'h6;
    localparam logic [3:0] OpEncMaddu = 4'h7;
    localparam logic [3:0] OpEncMsub  = 4'h8;
    localparam logic [3:0] OpEncMsubu = 4'h9;

    // Divider iteration counter width for the default 32-bit datapath
    localparam int unsigned DIV_CNT_W = $clog2(32 + 1);

    typedef enum logic [3:0] {
        OpMult  = OpEncMult,
        OpMultu = OpEncMultu,
        OpDiv   = OpEncDiv,
        OpDivu  = OpEncDivu,
        OpMthi  = OpEncMthi,
        OpMtlo  = OpEncMtlo,
        OpMadd  = OpEncMadd,
        OpMaddu = OpEncMaddu,
        OpMsub  = OpEncMsub,
        OpMsubu = OpEncMsubu
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMul    = 2'd1,
        StDiv    = 2'd2,
        StDivFix = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_unit_div.sv
// Restoring magnitude divider: loads on start, then one quotient bit per
// enabled cycle for WIDTH cycles. last is high during the final iteration.
module mips_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic             active_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Partial remainder with the next dividend bit shifted in, and trial subtract
    always_comb begin
        shifted = {rem_q, quot_q[WIDTH-1]};
        fits    = shifted >= {1'b0, dvs_q};
        // Modular subtract is exact whenever fits is set (result < divisor)
        diff    = shifted[WIDTH-1:0] - dvs_q;
    end

    assign last      = active_q && (cnt_q == CntLast);
    assign quotient  = quot_q;
    assign remainder = rem_q;

    // Iteration state; a zero divisor naturally yields all-ones and the dividend
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
        end else if (enable) begin
            if (start) begin
                active_q <= 1'b1;
                cnt_q    <= '0;
                rem_q    <= '0;
                quot_q   <= dividend;
                dvs_q    <= divisor;
            end else if (active_q) begin
                rem_q    <= fits ? diff : shifted[WIDTH-1:0];
                quot_q   <= {quot_q[WIDTH-2:0], fits};
                cnt_q    <= cnt_q + CntW'(1);
                if (last) active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined multiply, iterative divide, MTHI/MTLO.
// Optional feature macro: MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU;
// without it those encodings are ignored.
import mips_muldiv_pkg::*;

module mips_muldiv_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [2:0] MulLastCnt = 3'(MUL_STAGES - 1);

    muldiv_state_t    state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic             issue;
    logic             op_mul, op_div, op_signed, op_mthi, op_mtlo;
    logic [2:0]       mul_cnt_q;
    logic             mul_last;
    logic [PW-1:0]    rs_ext, rt_ext, product, mul_res, mul_wr;
    logic [PW-1:0]    mul_pipe_q [MUL_STAGES];
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic             div_last;
    logic [WIDTH-1:0] div_quot, div_rem;
    logic             div_neg_quot_q, div_neg_rem_q, div_zero_q;
    logic [WIDTH-1:0] div_rs_q;
`ifdef MULDIV_MADD_EN
    logic             op_acc, op_sub;
    logic             acc_q, sub_q;
`endif

    // Op decode
    always_comb begin
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_mthi   = 1'b0;
        op_mtlo   = 1'b0;
`ifdef MULDIV_MADD_EN
        op_acc    = 1'b0;
        op_sub    = 1'b0;
`endif
        case (op)
            OpMult:  begin op_mul = 1'b1; op_signed = 1'b1; end
            OpMultu: op_mul = 1'b1;
            OpDiv:   begin op_div = 1'b1; op_signed = 1'b1; end
            OpDivu:  op_div = 1'b1;
            OpMthi:  op_mthi = 1'b1;
            OpMtlo:  op_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
            OpMadd:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
            OpMaddu: begin op_mul = 1'b1; op_acc = 1'b1; end
            OpMsub:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
            OpMsubu: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign issue = start && (state_q == StIdle);

    // Operand conditioning: sign/zero extension for multiply, magnitudes for divide
    always_comb begin
        rs_ext  = {{WIDTH{op_signed & rs_val[WIDTH-1]}}, rs_val};
        rt_ext  = {{WIDTH{op_signed & rt_val[WIDTH-1]}}, rt_val};
        product = rs_ext * rt_ext;
        rs_mag  = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_mag  = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    assign mul_res = mul_pipe_q[MUL_STAGES-1];

`ifdef MULDIV_MADD_EN
    // Accumulate ops take one extra cycle after the product settles
    assign mul_last = (state_q == StMul) && (mul_cnt_q == MulLastCnt + 3'(acc_q));
    assign mul_wr   = !acc_q ? mul_res :
                      sub_q  ? ({hi_q, lo_q} - mul_res) : ({hi_q, lo_q} + mul_res);
`else
    assign mul_last = (state_q == StMul) && (mul_cnt_q == MulLastCnt);
    assign mul_wr   = mul_res;
`endif

    mips_div_iter #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .enable    (clk_enable),
        .start     (issue && op_div),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .last      (div_last),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Next state and HI/LO write selection; HI/LO only change on completion
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    if (op_mul) begin
                        state_d = StMul;
                    end else if (op_div) begin
                        state_d = StDiv;
                    end else if (op_mthi) begin
                        hi_d   = rs_val;
                        done_d = 1'b1;
                    end else if (op_mtlo) begin
                        lo_d   = rs_val;
                        done_d = 1'b1;
                    end
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d      = StIdle;
                    {hi_d, lo_d} = mul_wr;
                    done_d       = 1'b1;
                end
            end
            StDiv: begin
                if (div_last) state_d = StDivFix;
            end
            StDivFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = div_rs_q;
                end else begin
                    // MIN / -1 wraps back to MIN here, remainder is 0
                    lo_d = div_neg_quot_q ? -div_quot : div_quot;
                    hi_d = div_neg_rem_q ? -div_rem : div_rem;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, HI/LO, and per-op latched attributes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            hi_q           <= '0;
            lo_q           <= '0;
            done_q         <= 1'b0;
            mul_cnt_q      <= '0;
            div_neg_quot_q <= 1'b0;
            div_neg_rem_q  <= 1'b0;
            div_zero_q     <= 1'b0;
            div_rs_q       <= '0;
`ifdef MULDIV_MADD_EN
            acc_q          <= 1'b0;
            sub_q          <= 1'b0;
`endif
        end else if (clk_enable) begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            if (issue && op_mul) begin
                mul_cnt_q <= '0;
`ifdef MULDIV_MADD_EN
                acc_q     <= op_acc;
                sub_q     <= op_sub;
`endif
            end else if (state_q == StMul) begin
                mul_cnt_q <= mul_cnt_q + 3'd1;
            end
            if (issue && op_div) begin
                div_neg_quot_q <= op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                div_neg_rem_q  <= op_signed && rs_val[WIDTH-1];
                div_zero_q     <= (rt_val == '0);
                div_rs_q       <= rs_val;
            end
        end
    end

    // Multiply pipe: product enters at issue and ripples toward the last stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) mul_pipe_q[i] <= '0;
        end else if (clk_enable) begin
            if (issue && op_mul) mul_pipe_q[0] <= product;
            for (int i = 1; i < int'(MUL_STAGES); i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
        end
    end

    assign busy = (state_q != StIdle);
    // A completion seen during a freeze is presented on the next enabled cycle
    assign done = done_q && clk_enable;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit (WIDTH=32, MUL_STAGES=2) with a result scoreboard.
// Honors MULDIV_MADD_EN to pick the MADDU expectation.
import mips_muldiv_pkg::*;

module tb_mips_muldiv_unit;
    localparam int W  = 32;
    localparam int MS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic          start;
    muldiv_op_t    op;
    logic [W-1:0]  rs_val, rt_val;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mips_muldiv_unit #(
        .WIDTH      (W),
        .MUL_STAGES (MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Watch for stray completions over n cycles
    task automatic quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(tag, seen, 1'b0);
    endtask

    // Issue one op, wait for done, compare against the scoreboard head.
    // poke: wait cycle at which a second start is attempted (-1 none).
    // frz: wait cycle at which clk_enable drops for 5 cycles (-1 none).
    task automatic run_op(input string tag, input muldiv_op_t o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input int lat, input int poke,
                          input int frz);
        int   n;
        logic held, busy_ok;
        exp_t e;
        sb.push_back('{hi: eh, lo: el});
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        step();
        start = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        n = 0; held = 1'b1; busy_ok = 1'b1;
        while (!done && n < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== m_hi || lo !== m_lo) held = 1'b0;
            if (n == poke) begin
                start = 1'b1; op = OpMultu;
            end
            if (n == frz) clk_enable = 1'b0;
            step();
            n++;
            start = 1'b0; op = o;
            if (frz >= 0 && n == frz + 5) clk_enable = 1'b1;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " busy while pending"}, busy_ok, 1'b1);
        chk({tag, " hi/lo held"}, held, 1'b1);
        chk({tag, " busy at done"}, busy, 1'b0);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard underflow"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, hi, e.hi);
            chk({tag, " lo"}, lo, e.lo);
        end
        m_hi = eh; m_lo = el;
        step();
        chk({tag, " done single pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        longint       p;
        int           sa, sbv;

        reset = 1'b0; clk_enable = 1'b1; start = 1'b0; op = OpMult;
        rs_val = '0; rt_val = '0;
        #12;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset hi", hi, '0);
        chk("reset lo", lo, '0);
        @(negedge clk) reset = 1'b1;
        step();

        run_op("mult -3*7", OpMult, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MS, -1, -1);
        run_op("divu 100/7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, W + 1, -1, -1);
        run_op("div -7/2", OpDiv, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 1, -1, -1);
        run_op("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, W + 1,
               -1, -1);
        run_op("divu by 0", OpDivu, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, W + 1, 3, -1);
        quiet("ignored start no done", 8);
        run_op("div freeze", OpDiv, -32'sd100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, W + 6,
               -1, 10);

        // Reset in the middle of a divide aborts it
        op = OpDiv; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b0;
        #1;
        chk("midreset busy", busy, 1'b0);
        chk("midreset hi", hi, '0);
        chk("midreset lo", lo, '0);
        @(negedge clk) reset = 1'b1;
        m_hi = '0; m_lo = '0;
        quiet("midreset no done", W + 8);
        chk("midreset hi after", hi, '0);

        run_op("mthi", OpMthi, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, m_lo, 0, -1, -1);
        run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MS, -1, -1);
`ifdef MULDIV_MADD_EN
        run_op("maddu", OpMaddu, 32'd1, 32'd1, 32'd1, 32'hFFFF_FFFF, MS + 1, -1, -1);
`else
        op = OpMaddu; rs_val = 32'd1; rt_val = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("maddu noop busy", busy, 1'b0);
        quiet("maddu noop done", 6);
        chk("maddu noop hi", hi, m_hi);
        chk("maddu noop lo", lo, m_lo);
`endif
        run_op("mtlo", OpMtlo, 32'h1234_5678, 32'd0, m_hi, 32'h1234_5678, 0, -1, -1);

        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom;
            p = longint'($signed(a)) * longint'($signed(b));
            run_op("mult rand", OpMult, a, b, p[63:32], p[31:0], MS, -1, -1);
            b = $urandom_range(1, 70000);
            run_op("divu rand", OpDivu, a, b, a % b, a / b, W + 1, -1, -1);
            sa  = $signed(a);
            sbv = int'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) sbv = -sbv;
            run_op("div rand", OpDiv, a, sbv, sa % sbv, sa / sbv, W + 1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
